// File: rtl/rename_stage.sv
// rename_stage: 32-entry map table, FIFO free list, one branch checkpoint.
// Define RENAME_ASSERT_EN to compile the simulation-only protocol checks.
package rename_pkg;
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  Opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        fu_alu;
    logic        fu_mem;
    logic        fu_br;
  } decode_data;

  typedef struct packed {
    decode_data dec;
    logic [6:0] ps1;
    logic [6:0] ps2;
    logic [6:0] pd_new;
    logic [6:0] pd_old;
  } rename_data;
endpackage

module rename_stage
  import rename_pkg::*;
#(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  decode_data data_in,
  output logic       ready_in,
  output logic       valid_out,
  output rename_data data_out,
  input  logic       ready_out,
  input  logic       commit_valid,
  input  logic [6:0] commit_pd_old,
  input  logic       branch_resolved,
  input  logic       mispredict,
  output logic [6:0] free_count
);
  localparam int PW = $clog2(NUM_PREGS);
  localparam logic [PW-1:0] INIT_FREE =
    PW'(NUM_PREGS - NUM_AREGS);

  logic [PW-1:0] map_q      [NUM_AREGS];
  logic [PW-1:0] map_d      [NUM_AREGS];
  logic [PW-1:0] ckpt_map_q [NUM_AREGS];
  logic [PW-1:0] ckpt_map_d [NUM_AREGS];
  logic [PW-1:0] free_q     [NUM_PREGS];
  logic [PW-1:0] free_d     [NUM_PREGS];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] ckpt_head_q, ckpt_head_d;
  logic          ckpt_valid_q, ckpt_valid_d;
  logic          valid_out_q, valid_out_d;
  rename_data    data_out_q, data_out_d;

  logic          accept;
  logic          alloc;
  logic          push;
  logic          recover;
  logic          take_ckpt;
  logic [PW-1:0] pd_new;

  assign free_count = tail_q - head_q;
  assign ready_in   = !mispredict
                   && (!valid_out_q || ready_out)
                   && (data_in.rd == '0 || free_count != '0)
                   && !(data_in.fu_br && ckpt_valid_q);
  assign accept     = valid_in && ready_in;
  assign alloc      = accept && data_in.rd != '0;
  assign take_ckpt  = accept && data_in.fu_br;
  assign push       = commit_valid && commit_pd_old != '0;
  assign recover    = mispredict && ckpt_valid_q;
  assign pd_new     = alloc ? free_q[head_q] : '0;
  assign valid_out  = valid_out_q;
  assign data_out   = data_out_q;

  // Map update; the checkpoint copy includes the branch's own rd write.
  always_comb begin
    map_d      = map_q;
    ckpt_map_d = ckpt_map_q;
    if (alloc) map_d[data_in.rd] = pd_new;
    if (take_ckpt) ckpt_map_d = map_d;
    if (recover) map_d = ckpt_map_q;
  end

  // Free-list pointers; recovery rewinds head but leaves tail alone.
  always_comb begin
    free_d      = free_q;
    head_d      = alloc ? head_q + PW'(1) : head_q;
    ckpt_head_d = take_ckpt ? head_d : ckpt_head_q;
    tail_d      = push ? tail_q + PW'(1) : tail_q;
    if (push) free_d[tail_q] = commit_pd_old;
    if (recover) head_d = ckpt_head_q;
  end

  // Checkpoint ownership: a new branch claims it, resolve/flush frees it.
  always_comb begin
    ckpt_valid_d = ckpt_valid_q;
    if (recover || branch_resolved) ckpt_valid_d = 1'b0;
    if (take_ckpt) ckpt_valid_d = 1'b1;
  end

  // Output register: load on accept, drain on ready, drop on flush.
  always_comb begin
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    if (accept) begin
      valid_out_d       = 1'b1;
      data_out_d.dec    = data_in;
      data_out_d.ps1    = map_q[data_in.rs1];
      data_out_d.ps2    = map_q[data_in.rs2];
      data_out_d.pd_new = pd_new;
      data_out_d.pd_old = alloc ? map_q[data_in.rd] : '0;
    end else if (ready_out) begin
      valid_out_d = 1'b0;
    end
    if (recover) valid_out_d = 1'b0;
  end

  // Map table and checkpoint copy; identity mapping out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        map_q[i]      <= PW'(i);
        ckpt_map_q[i] <= PW'(i);
      end
    end else begin
      map_q      <= map_d;
      ckpt_map_q <= ckpt_map_d;
    end
  end

  // Free-list storage; starts holding every tag above the arch set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        free_q[i] <= (i < NUM_PREGS - NUM_AREGS)
                   ? PW'(i + NUM_AREGS) : '0;
      end
    end else begin
      free_q <= free_d;
    end
  end

  // Pointers, checkpoint state and the output packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= INIT_FREE;
      ckpt_head_q  <= '0;
      ckpt_valid_q <= 1'b0;
      valid_out_q  <= 1'b0;
      data_out_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      ckpt_head_q  <= ckpt_head_d;
      ckpt_valid_q <= ckpt_valid_d;
      valid_out_q  <= valid_out_d;
      data_out_q   <= data_out_d;
    end
  end

`ifdef RENAME_ASSERT_EN
  function automatic logic in_free(input logic [PW-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_PREGS; i++) begin
      if (PW'(i) < free_count && free_q[head_q + PW'(i)] == tag)
        hit = 1'b1;
    end
    return hit;
  endfunction

  // Flag protocol violations sampled at each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      if (push && free_count == INIT_FREE)
        $error("rename: push into full free list");
      if (alloc && free_count == '0)
        $error("rename: allocate from empty free list");
      if ((mispredict || branch_resolved) && !ckpt_valid_q)
        $error("rename: resolve without checkpoint");
      if (push && in_free(commit_pd_old))
        $error("rename: double free of p%0d", commit_pd_old);
    end
  end
`endif

endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed stimulus, queue-based reference model,
// per-cycle compare plus literal spot checks.
module tb_rename_stage;
  import rename_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_in = 1'b0;
  decode_data data_in = '0;
  logic       ready_in;
  logic       valid_out;
  rename_data data_out;
  logic       ready_out = 1'b1;
  logic       commit_valid = 1'b0;
  logic [6:0] commit_pd_old = '0;
  logic       branch_resolved = 1'b0;
  logic       mispredict = 1'b0;
  logic [6:0] free_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rename_stage dut (
    .clk(clk), .reset(reset),
    .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out),
    .data_out(data_out), .ready_out(ready_out),
    .commit_valid(commit_valid),
    .commit_pd_old(commit_pd_old),
    .branch_resolved(branch_resolved),
    .mispredict(mispredict),
    .free_count(free_count)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: the free list is a plain queue; tags popped since
  // the checkpoint are remembered and pushed back to the front on flush.
  int         m_map  [32];
  int         c_map  [32];
  int         fl     [$];
  int         since  [$];
  bit         ckv;
  bit         mvalid;
  rename_data mdata;

  function automatic bit m_ready();
    return !mispredict && (!mvalid || ready_out)
        && (data_in.rd == 0 || fl.size() != 0)
        && !(data_in.fu_br && ckv);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_map[i] = i;
      c_map[i] = i;
    end
    fl.delete();
    for (int i = 32; i < 128; i++) fl.push_back(i);
    since.delete();
    ckv    = 1'b0;
    mvalid = 1'b0;
    mdata  = '0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_reset();
    end else begin
      bit         acc;
      bit         ck0;
      rename_data p;
      int         pn;
      ck0 = ckv;
      acc = valid_in && m_ready();
      p   = '0;
      if (acc) begin
        p.dec = data_in;
        p.ps1 = 7'(m_map[data_in.rs1]);
        p.ps2 = 7'(m_map[data_in.rs2]);
        if (data_in.rd != 0) begin
          pn = fl.pop_front();
          p.pd_new = 7'(pn);
          p.pd_old = 7'(m_map[data_in.rd]);
          m_map[data_in.rd] = pn;
          if (ckv) since.push_back(pn);
        end
        if (data_in.fu_br) begin
          c_map = m_map;
          since.delete();
          ckv = 1'b1;
        end
      end
      if (commit_valid && commit_pd_old != 0)
        fl.push_back(int'(commit_pd_old));
      if (mispredict && ck0) begin
        m_map = c_map;
        while (since.size() > 0) fl.push_front(since.pop_back());
        ckv = 1'b0;
      end else if (branch_resolved && !(acc && data_in.fu_br)) begin
        ckv = 1'b0;
      end
      if (mispredict && ck0) mvalid = 1'b0;
      else if (acc) begin
        mvalid = 1'b1;
        mdata  = p;
      end else if (ready_out) mvalid = 1'b0;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (reset) begin
      chk("ready_in", ready_in, m_ready());
      chk("free_count", free_count, fl.size());
      chk("valid_out", valid_out, mvalid);
      if (mvalid) begin
        checks++;
        if (data_out !== mdata) begin
          errors++;
          $display("FAIL data_out actual=%h required=%h",
                   data_out, mdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int rs1, input int rs2,
                    input int rd, input bit br);
    valid_in       = 1'b1;
    data_in        = '0;
    data_in.rs1    = 5'(rs1);
    data_in.rs2    = 5'(rs2);
    data_in.rd     = 5'(rd);
    data_in.pc     = 32'h1000 + 32'(rd * 4);
    data_in.imm    = 32'(rs1 + rs2);
    data_in.Opcode = br ? 7'h63 : 7'h33;
    data_in.func3  = 3'(rd);
    data_in.fu_br  = br;
    data_in.fu_alu = !br;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  initial begin
    rename_data held;
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_free_count", free_count, 96);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_pc", data_out.dec.pc, 0);
    chk("rst_data_pd", data_out.pd_new, 0);
    reset = 1'b1;

    // add x5,x1,x2 then a reader of x5
    op(1, 2, 5, 0); tick();
    chk("add_ps1", data_out.ps1, 1);
    chk("add_ps2", data_out.ps2, 2);
    chk("add_pd_old", data_out.pd_old, 5);
    chk("add_pd_new", data_out.pd_new, 32);
    chk("add_free_count", free_count, 95);
    op(5, 0, 6, 0); tick();
    chk("raw_ps1", data_out.ps1, 32);
    chk("raw_pd_new", data_out.pd_new, 33);

    // rd==x0 and p0 commit
    op(5, 6, 0, 0); tick();
    chk("x0_pd_new", data_out.pd_new, 0);
    chk("x0_pd_old", data_out.pd_old, 0);
    chk("x0_ps2", data_out.ps2, 33);
    chk("x0_free_count", free_count, 94);
    idle(); commit_valid = 1'b1; commit_pd_old = 7'd0; tick();
    commit_valid = 1'b0;
    chk("p0_commit_ignored", free_count, 94);
    chk("drain_valid_out", valid_out, 0);

    // backpressure
    op(1, 1, 7, 0); tick();
    ready_out = 1'b0;
    op(2, 2, 8, 0); #1;
    chk("bp_ready_in", ready_in, 0);
    held = data_out;
    tick(); tick();
    chk("bp_hold_pd", data_out.pd_new, 34);
    chk("bp_hold_rd", data_out.dec.rd, 7);
    chk("bp_hold_pc", data_out.dec.pc, held.dec.pc);
    chk("bp_hold_valid", valid_out, 1);
    ready_out = 1'b1; #1;
    chk("bp_release_ready", ready_in, 1);
    tick();
    chk("bp_next_rd", data_out.dec.rd, 8);
    chk("bp_next_pd", data_out.pd_new, 35);

    // exhaustion
    for (int i = 0; i < 120 && fl.size() > 0; i++) begin
      op(i % 31 + 1, (i + 3) % 31 + 1, i % 31 + 1, 0);
      tick();
    end
    op(3, 4, 9, 0); #1;
    chk("exh_free_count", free_count, 0);
    chk("exh_ready_in", ready_in, 0);
    commit_valid = 1'b1; commit_pd_old = 7'd5; tick();
    commit_valid = 1'b0;
    chk("exh_push_count", free_count, 1);
    chk("exh_ready_again", ready_in, 1);
    tick();
    chk("exh_pd_new", data_out.pd_new, 5);
    chk("exh_rd", data_out.dec.rd, 9);
    idle();

    // asynchronous reset mid-cycle
    @(posedge clk); #3;
    reset = 1'b0; #1;
    chk("async_valid_out", valid_out, 0);
    chk("async_free_count", free_count, 96);
    tick();
    reset = 1'b1;

    // branch, two younger ops, commit + mispredict
    for (int r = 1; r <= 8; r++) begin
      op(r, 0, r, 0); tick();
    end
    op(1, 2, 9, 1); tick();
    chk("br_pd_new", data_out.pd_new, 40);
    op(9, 0, 10, 0); tick();
    chk("y1_pd_new", data_out.pd_new, 41);
    chk("y1_ps1", data_out.ps1, 40);
    op(10, 0, 11, 0); tick();
    chk("y2_pd_new", data_out.pd_new, 42);
    idle();
    commit_valid = 1'b1; commit_pd_old = 7'd7; mispredict = 1'b1; #1;
    chk("mp_ready_in", ready_in, 0);
    tick();
    commit_valid = 1'b0; mispredict = 1'b0;
    chk("mp_free_count", free_count, 88);
    chk("mp_valid_out", valid_out, 0);
    op(10, 9, 12, 0); tick();
    chk("mp_ps1_reverted", data_out.ps1, 10);
    chk("mp_ps2_kept", data_out.ps2, 40);
    chk("mp_pd_new", data_out.pd_new, 41);
    op(11, 0, 13, 0); tick();
    chk("mp_x11_reverted", data_out.ps1, 11);
    chk("mp_pd_new2", data_out.pd_new, 42);

    // second branch stalls until the first resolves
    op(1, 0, 14, 1); tick();
    chk("b1_pd_new", data_out.pd_new, 43);
    op(14, 0, 15, 1); #1;
    chk("b2_stall", ready_in, 0);
    tick();
    chk("b2_stall_valid", valid_out, 0);
    branch_resolved = 1'b1; #1;
    chk("b2_resolve_cycle", ready_in, 0);
    tick();
    branch_resolved = 1'b0; #1;
    chk("b2_ready", ready_in, 1);
    tick();
    chk("b2_rd", data_out.dec.rd, 15);
    chk("b2_pd_new", data_out.pd_new, 44);
    chk("b2_ps1", data_out.ps1, 43);
    op(15, 0, 16, 0); tick();
    chk("b2_young_pd", data_out.pd_new, 45);
    idle(); mispredict = 1'b1; tick();
    mispredict = 1'b0;
    op(16, 15, 17, 0); tick();
    chk("b2_ps1_reverted", data_out.ps1, 16);
    chk("b2_ps2_kept", data_out.ps2, 44);
    chk("b2_pd_reused", data_out.pd_new, 45);
    idle();
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
